// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, entry type and constants for the write-back arbiter
package wb_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   localparam logic [ADDR_W-1:0] WB_ZERO_REG = '0;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - load-return circular buffer with per-entry valid bits
// Entries can be invalidated by destination address while they wait.
module wb_fifo #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [ADDR_W-1:0]        push_addr_i,
   input  logic [DATA_W-1:0]        push_data_i,
   input  logic                     pop_i,
   input  logic                     squash_i,
   input  logic [ADDR_W-1:0]        squash_addr_i,
   output logic                     squash_hit_o,
   output logic                     head_valid_o,
   output logic [ADDR_W-1:0]        head_addr_o,
   output logic [DATA_W-1:0]        head_data_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [DEPTH-1:0]  hit;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;

   always_comb begin
      hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hit[i] = valid_q[i] && (addr_q[i] == squash_addr_i);
      end
      valid_d  = valid_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      // Push is applied after the squash so a same-cycle arrival stays valid.
      if (squash_i) valid_d = valid_q & ~hit;
      if (pop_i) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = rd_ptr_q + 1'b1;
      end
      if (push_i) begin
         valid_d[wr_ptr_q] = 1'b1;
         wr_ptr_d          = wr_ptr_q + 1'b1;
      end
      count_d = count_q + {{PTR_W{1'b0}}, push_i} - {{PTR_W{1'b0}}, pop_i};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) begin
         addr_q[wr_ptr_q] <= push_addr_i;
         data_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign squash_hit_o = squash_i && (hit != '0);
   assign head_valid_o = valid_q[rd_ptr_q];
   assign head_addr_o  = addr_q[rd_ptr_q];
   assign head_data_o  = data_q[rd_ptr_q];
   assign count_o      = count_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - register-file write-port arbiter, ALU over buffered load returns
// Optional load scoreboard enabled by defining WB_SCOREBOARD_EN.
module wb_write_arbiter
   import wb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = wb_pkg::DATA_W,
   parameter int ADDR_W = wb_pkg::ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              alu_valid_i,
   input  logic [ADDR_W-1:0] alu_addr_i,
   input  logic [DATA_W-1:0] alu_data_i,
   input  logic              mem_valid_i,
   output logic              mem_ready_o,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_data_i,
`ifdef WB_SCOREBOARD_EN
   input  logic              issue_valid_i,
   input  logic [ADDR_W-1:0] issue_addr_i,
   output logic [31:0]       busy_o,
`endif
   output logic              RegWrite_o,
   output logic [ADDR_W-1:0] RDaddr_o,
   output logic [DATA_W-1:0] RDdata_o
);

   localparam int                CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] ZERO  = ADDR_W'(WB_ZERO_REG);

   logic [CNT_W-1:0]  count;
   logic              alu_go, fifo_sel, push, squash_hit, head_valid;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;

   assign alu_go      = alu_valid_i && (alu_addr_i != ZERO);
   assign fifo_sel    = !alu_go && (count != '0);
   assign mem_ready_o = (count != FULL) && !rst_i;
   assign push        = mem_valid_i && mem_ready_o && (mem_addr_i != ZERO);

   wb_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .push_i        (push),
      .push_addr_i   (mem_addr_i),
      .push_data_i   (mem_data_i),
      .pop_i         (fifo_sel),
      .squash_i      (alu_go),
      .squash_addr_i (alu_addr_i),
      .squash_hit_o  (squash_hit),
      .head_valid_o  (head_valid),
      .head_addr_o   (head_addr),
      .head_data_o   (head_data),
      .count_o       (count)
   );

   // A squashed head is still popped, but yields an idle write cycle.
   always_comb begin
      wr_en_d = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      if (alu_go) begin
         wr_en_d = 1'b1;
         addr_d  = alu_addr_i;
         data_d  = alu_data_i;
      end else if (fifo_sel && head_valid) begin
         wr_en_d = 1'b1;
         addr_d  = head_addr;
         data_d  = head_data;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_en_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         wr_en_q <= wr_en_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign RegWrite_o = wr_en_q;
   assign RDaddr_o   = addr_q;
   assign RDdata_o   = data_q;

`ifdef WB_SCOREBOARD_EN
   logic [31:0] busy_q, busy_d;

   // Set is evaluated last so a new issue overrides a same-cycle completion.
   always_comb begin
      busy_d = busy_q;
      for (int b = 1; b < 32; b++) begin
         if (fifo_sel && head_valid && (head_addr == ADDR_W'(b))) busy_d[b] = 1'b0;
         if (squash_hit && (alu_addr_i == ADDR_W'(b)))            busy_d[b] = 1'b0;
         if (issue_valid_i && (issue_addr_i == ADDR_W'(b)))       busy_d[b] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) busy_q <= '0;
      else       busy_q <= busy_d;
   end

   assign busy_o = busy_q;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb/tb_wb_write_arbiter.sv - scoreboard bench for the write-back arbiter
module tb_wb_write_arbiter;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              alu_valid, mem_valid, mem_ready;
   logic [ADDR_W-1:0] alu_addr, mem_addr, rd_addr;
   logic [DATA_W-1:0] alu_data, mem_data, rd_data;
   logic              reg_write;
`ifdef WB_SCOREBOARD_EN
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_addr;
   logic [31:0]       busy;
`endif

   exp_t exp_q[$];
   int   checks = 0;
   int   passes = 0;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;

   wb_write_arbiter #(.DEPTH(4), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .alu_valid_i (alu_valid),
      .alu_addr_i  (alu_addr),
      .alu_data_i  (alu_data),
      .mem_valid_i (mem_valid),
      .mem_ready_o (mem_ready),
      .mem_addr_i  (mem_addr),
      .mem_data_i  (mem_data),
`ifdef WB_SCOREBOARD_EN
      .issue_valid_i (issue_valid),
      .issue_addr_i  (issue_addr),
      .busy_o        (busy),
`endif
      .RegWrite_o  (reg_write),
      .RDaddr_o    (rd_addr),
      .RDdata_o    (rd_data)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   function automatic exp_t mk(input int a, input logic [DATA_W-1:0] d);
      exp_t e;
      e.a = ADDR_W'(a);
      e.d = d;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_en && reg_write === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", rd_addr, rd_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("wb_addr", rd_addr, e.a);
            check("wb_data", rd_data, e.d);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
      mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
`ifdef WB_SCOREBOARD_EN
      issue_valid = 1'b0; issue_addr = '0;
`endif
      repeat (3) tick();
      check("rst_regwrite", reg_write, 0);
      check("rst_rdaddr", rd_addr, 0);
      check("rst_rddata", rd_data, 0);
      check("rst_ready_held", mem_ready, 0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", mem_ready, 1);
      mon_en = 1'b1;
      tick();

      // ALU only, then an r0 request that must not write
      alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h12345678;
      exp_q.push_back(mk(3, 32'h12345678));
      tick();
      check("alu_latency", reg_write, 1);
      alu_addr = 5'd0; alu_data = 32'hFFFFFFFF;
      tick();
      check("r0_nowrite", reg_write, 0);
      check("r0_addr_hold", rd_addr, 3);
      check("r0_data_hold", rd_data, 32'h12345678);
      alu_addr = 5'd31; alu_data = 32'hDEADBEEF;
      exp_q.push_back(mk(31, 32'hDEADBEEF));
      tick();
      alu_valid = 1'b0;
      tick();
      check("idle_nowrite", reg_write, 0);

      // Contention: loads 4..7 arrive under a continuous ALU stream
      for (int k = 0; k < 6; k++) begin
         alu_valid = 1'b1; alu_addr = ADDR_W'(10 + k); alu_data = 32'h100 + k;
         exp_q.push_back(mk(10 + k, 32'h100 + k));
         if (k < 4) begin
            check("ready_before_push", mem_ready, 1);
            mem_valid = 1'b1; mem_addr = ADDR_W'(4 + k); mem_data = 32'h4000 + k;
         end else begin
            check("ready_full", mem_ready, 0);
            mem_valid = 1'b0;
         end
         tick();
      end
      for (int k = 0; k < 4; k++) exp_q.push_back(mk(4 + k, 32'h4000 + k));
      alu_valid = 1'b0; mem_valid = 1'b0;
      check("ready_full_pop_cycle", mem_ready, 0);
      tick();
      check("ready_after_pop", mem_ready, 1);
      check("drain_write0", reg_write, 1);
      for (int k = 1; k < 4; k++) begin
         tick();
         check("drain_consecutive", reg_write, 1);
      end
      tick();
      check("drain_done", reg_write, 0);

      // Squash: queued r9 load overtaken by an ALU write to r9
      mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'hAAAA;
      tick();
      mem_valid = 1'b0;
      alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h5555;
      exp_q.push_back(mk(9, 32'h5555));
      tick();
      check("squash_alu_write", reg_write, 1);
      alu_valid = 1'b0;
      tick();
      check("squash_pop_nowrite", reg_write, 0);
      check("squash_data_hold", rd_data, 32'h5555);
      tick();

      // Same-cycle ALU and load to the same register: load is not squashed
      alu_valid = 1'b1; alu_addr = 5'd13; alu_data = 32'h1;
      mem_valid = 1'b1; mem_addr = 5'd13; mem_data = 32'h2;
      exp_q.push_back(mk(13, 32'h1));
      exp_q.push_back(mk(13, 32'h2));
      tick();
      alu_valid = 1'b0; mem_valid = 1'b0;
      repeat (2) tick();

      // Load to r0 completes the handshake without being queued
      mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'hBAD;
      check("r0_load_ready", mem_ready, 1);
      tick();
      mem_valid = 1'b0;
      tick();
      check("r0_load_nowrite", reg_write, 0);

      // Pointer wrap over ten back-to-back loads
      for (int i = 0; i < 10; i++) begin
         check("wrap_ready", mem_ready, 1);
         mem_valid = 1'b1; mem_addr = ADDR_W'(16 + i); mem_data = 32'hC0DE0000 + i;
         exp_q.push_back(mk(16 + i, 32'hC0DE0000 + i));
         tick();
      end
      mem_valid = 1'b0;
      repeat (3) tick();

      // Reset mid-operation discards queued loads and the granted write
      alu_valid = 1'b1; alu_addr = 5'd20; alu_data = 32'hA1;
      mem_valid = 1'b1; mem_addr = 5'd21; mem_data = 32'hB1;
      exp_q.push_back(mk(20, 32'hA1));
      tick();
      alu_addr = 5'd22; alu_data = 32'hA2;
      mem_addr = 5'd23; mem_data = 32'hB2;
      exp_q.push_back(mk(22, 32'hA2));
      tick();
      rst = 1'b1; mem_valid = 1'b0;
      alu_addr = 5'd24; alu_data = 32'hA3;
      tick();
      check("midrst_regwrite", reg_write, 0);
      check("midrst_rdaddr", rd_addr, 0);
      check("midrst_rddata", rd_data, 0);
      check("midrst_ready", mem_ready, 0);
      rst = 1'b0; alu_valid = 1'b0;
      #1;
      check("midrst_ready_release", mem_ready, 1);
      repeat (4) tick();

`ifdef WB_SCOREBOARD_EN
      issue_valid = 1'b1; issue_addr = 5'd12;
      tick();
      issue_valid = 1'b0;
      check("sb_set", busy[12], 1);
      mem_valid = 1'b1; mem_addr = 5'd12; mem_data = 32'h1200;
      exp_q.push_back(mk(12, 32'h1200));
      tick();
      mem_valid = 1'b0;
      check("sb_pending", busy[12], 1);
      tick();
      check("sb_load_write", reg_write, 1);
      tick();
      check("sb_cleared", busy[12], 0);
      mem_valid = 1'b1; mem_addr = 5'd12; mem_data = 32'h1201;
      exp_q.push_back(mk(12, 32'h1201));
      tick();
      mem_valid = 1'b0;
      issue_valid = 1'b1; issue_addr = 5'd12;
      tick();
      issue_valid = 1'b0;
      check("sb_set_wins", busy[12], 1);
      tick();
      check("sb_set_holds", busy[12], 1);
      issue_valid = 1'b1; issue_addr = 5'd0;
      tick();
      issue_valid = 1'b0;
      check("sb_r0_zero", busy[0], 0);
      tick();
`endif

      repeat (3) tick();
      check("exp_drained", exp_q.size(), 0);
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
